// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic unit: the serial adder state encoding
// and the default operand width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package arith_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// ----------------------------------------------------------------------------
// serial_adder_if
// Operand-side and result-side valid/ready handshake bundle for serial_adder.
// Ports: none. Signals:
//   in_valid, in0, in1, cin  : producer -> adder
//   in_ready                 : adder -> producer
//   out_ready                : consumer -> adder
//   out_valid, sum, cout     : adder -> consumer
//   busy                     : adder status
// Modports: master (producer/consumer side), slave (adder side).
// ----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, in0, in1, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, in0, in1, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );

endinterface

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell of the arithmetic unit.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
// ----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder: sum = in0 + in1 + cin computed LSB first, one
// bit per clock, through a single full_adder cell.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, highest priority
//   bus : serial_adder_if slave modport (operand and result handshakes,
//         sum, cout, busy)
// ----------------------------------------------------------------------------
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_inReady;
   logic             r_outValid;
   logic             r_busy;

   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_accNext;

   // The single adder cell always looks at the current LSBs and running carry
   full_adder u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts the first bit
   // computed has arrived at bit 0
   assign w_accNext = {w_s, r_acc[WIDTH-1:1]};

   // Control FSM and datapath. Handshake/status outputs are registered next
   // to the state so they never depend combinationally on any input. The
   // result registers only move on the RUN-to-DONE edge, so they keep the
   // previous answer visible through IDLE and the following RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a       <= bus.in0;
                  r_b       <= bus.in1;
                  r_carry   <= bus.cin;
                  r_count   <= '0;
                  r_state   <= RUN;
                  r_inReady <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            RUN: begin
               r_acc   <= w_accNext;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_c;
               r_count <= r_count + 1'b1;
               if (r_count == LAST_BIT) begin
                  r_sum      <= w_accNext;
                  r_cout     <= w_c;
                  r_state    <= DONE;
                  r_busy     <= 1'b0;
                  r_outValid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_inReady  <= 1'b1;
               r_outValid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.busy      = r_busy;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder computing sum = in0 + in1 + cin one bit per clock, LSB first, through a single full-adder cell. It is the addition counterpart of the combinational ripple-borrow subtractor in the arithmetic unit. It trades latency for area, and connects to the rest of the ALU datapath through valid/ready handshakes on both the operand side and the result side.

## Interface
- WIDTH, 16, operand and result width in bits; legal range 2 or more.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; highest priority.
- in_valid  input  1  operands and cin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in0  input  WIDTH  first addend.
- in1  input  WIDTH  second addend.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout hold a completed result; high only in DONE.
- out_ready  input  1  downstream consumes the result.
- sum  output  WIDTH  result, low WIDTH bits of in0+in1+cin.
- cout  output  1  carry-out, bit WIDTH of in0+in1+cin.
- busy  output  1  high in RUN.

## Operation
- Operand transfer: in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- State IDLE:
  - in_ready=1.
  - On operand transfer: load shift registers a<=in0, b<=in1, carry<=cin, bit counter<=0, then go to RUN.
  - Operands are sampled only on that edge.
- State RUN: each cycle the full adder takes a[0], b[0] and carry.
  - Its sum bit shifts into the MSB of an accumulating shift register (shift right).
  - a and b shift right; carry is updated from the adder's carry-out; counter increments.
  - On the edge where counter==WIDTH-1, the final bit is processed, the assembled WIDTH-bit value is copied into the sum output register, the final carry is copied into cout, and the state goes to DONE.
  - in_valid is ignored in RUN.
- State DONE:
  - out_valid=1; sum and cout stable.
  - On result transfer, go to IDLE. in_ready rises the following cycle; there is no same-cycle bypass.
- Arithmetic is unsigned modulo 2^WIDTH. Examples: 0xFFFF+0x0000+1 gives sum 0x0000, cout 1. 0x8000+0x8000+0 gives sum 0x0000, cout 1.
- The sum and cout output registers change only on the RUN-to-DONE edge and on reset. They hold their last result through IDLE and the next RUN.
- Reset:
  - Reset in any state, including mid-RUN, forces IDLE and clears sum, cout, shift registers, carry and counter to 0.
  - out_valid=0, busy=0, in_ready=1 from the first cycle after rst deasserts.
  - An in-flight operation is discarded.

## Timing
- Latency: operand transfer at edge E. out_valid is high from edge E+WIDTH (WIDTH RUN cycles).
- Minimum initiation interval is WIDTH+2 cycles: WIDTH RUN cycles, 1 DONE cycle with out_ready high, 1 IDLE cycle.
- Backpressure: out_valid, sum and cout stay constant while out_ready=0, for any number of cycles.
- out_valid, in_ready and busy are decoded from registered state only, with no combinational input-to-output paths.
- in_valid asserted while in_ready=0 has no effect. The producer must hold its data until it sees the transfer.

## Structure
- Shared package, arith_pkg: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2, and the default WIDTH constant of 16.
- One sub-module: full_adder, the one-bit cell (a, b, cin in; s, cout out) already used by the arithmetic unit.
- Counter width: clog2(WIDTH).

## Test plan
- After reset, 0+0+0: in_ready=1, out_valid=0 before the transfer. out_valid rises exactly 16 cycles after the transfer, with sum=0, cout=0.
- 50+100+1 gives sum=151, cout=0. 65535+0+1 gives sum=0, cout=1. 32768+32768+1 gives sum=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands. sum and cout are unchanged, in_ready=0, no new operation starts. Release out_ready: in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at RUN cycle 7 of 0x1234+0x4321. The next cycle shows IDLE, sum=0, cout=0, out_valid=0. A following 0x1234+0x4321+0 returns 0x5555, cout=0.
- Back-to-back: out_ready tied high and in_valid always high with 100 random operand sets. Every result matches the 17-bit reference sum, with a WIDTH+2-cycle interval.
